// File: rtl/vram_pkg.sv
// Shared geometry, FSM state and output-beat types for the VRAM scan-out path.
package vram_pkg;

  localparam int unsigned COLS        = 128;
  localparam int unsigned ROWS        = 32;
  localparam int unsigned PAGES       = 4;
  localparam int unsigned ADR_W       = 12;
  localparam int unsigned X_LSB       = 5;
  localparam int unsigned Y_W         = 5;
  localparam int unsigned FETCH_CYC   = 10;
  localparam int unsigned FRAME_BYTES = 512;

  localparam int unsigned COL_W     = 7;
  localparam int unsigned PAGE_W    = 2;
  localparam int unsigned IDX_W     = COL_W + PAGE_W;
  localparam int unsigned ROW_LSB_W = Y_W - PAGE_W;
  localparam int unsigned PH_W      = 4;
  localparam int unsigned BYTE_W    = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_HOLD,
    ST_DRAIN
  } scan_state_t;

  typedef struct packed {
    logic              first;
    logic              last;
    logic [BYTE_W-1:0] dat;
  } pix_beat_t;

endpackage

// File: rtl/vram_scanout_if.sv
// Byte stream from the scan-out block to the display serializer.
interface vram_scanout_if;

  logic [7:0] m_dat_o;
  logic       m_valid_o;
  logic       m_ready_i;
  logic       m_first_o;
  logic       m_last_o;

  modport master (
    output m_dat_o,
    output m_valid_o,
    output m_first_o,
    output m_last_o,
    input  m_ready_i
  );

  modport slave (
    input  m_dat_o,
    input  m_valid_o,
    input  m_first_o,
    input  m_last_o,
    output m_ready_i
  );

endinterface

// File: rtl/vram_byte_fetch.sv
// Fetches one page-format byte (8 vertical pixels of one column) from the
// VRAM pixel port in ten cycles, F0..F9.
module vram_byte_fetch
  import vram_pkg::*;
#(
  parameter bit INVERT = 1'b0
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_ni,
  input  logic                go_i,
  input  logic [COL_W-1:0]    col_i,
  input  logic [PAGE_W-1:0]   page_i,
  output logic [BYTE_W-1:0]   byte_c,
  output logic                byte_valid_c,
  output logic [ADR_W-1:0]    gb_adr_o,
  input  logic                gb_pix_i
);

  logic              active_q;
  logic [PH_W-1:0]   phase_q;
  logic [BYTE_W-1:0] sh_q;
  logic              pix_c;
  logic              capture_c;
  logic              step_row_c;

  assign pix_c        = gb_pix_i ^ INVERT;
  assign byte_valid_c = active_q && (phase_q == PH_W'(FETCH_CYC - 1));
  // Pixel pipeline is two deep: the bit for row k arrives at F(k+2).
  assign capture_c    = active_q && (phase_q >= PH_W'(2));
  assign step_row_c   = active_q && (phase_q >= PH_W'(1)) && (phase_q <= PH_W'(7));
  // In F9 the final bit is still on gb_pix_i; forward it so the byte can
  // leave on the same edge it completes.
  assign byte_c       = byte_valid_c ? {pix_c, sh_q[BYTE_W-1:1]} : sh_q;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      active_q <= 1'b0;
      phase_q  <= '0;
      sh_q     <= '0;
      gb_adr_o <= '0;
    end else begin
      if (go_i) begin
        active_q                     <= 1'b1;
        phase_q                      <= '0;
        gb_adr_o[ADR_W-1:X_LSB]      <= col_i;
        gb_adr_o[X_LSB-1:ROW_LSB_W]  <= page_i;
        gb_adr_o[ROW_LSB_W-1:0]      <= '0;
      end else if (active_q) begin
        if (byte_valid_c) begin
          active_q <= 1'b0;
        end else begin
          phase_q <= phase_q + PH_W'(1);
        end
        if (step_row_c) begin
          gb_adr_o[ROW_LSB_W-1:0] <= phase_q[ROW_LSB_W-1:0];
        end
      end
      if (capture_c) begin
        sh_q <= {pix_c, sh_q[BYTE_W-1:1]};
      end
    end
  end

endmodule

// File: rtl/vram_scanout.sv
// Scans the 128x32 1bpp framebuffer into 512 page-format bytes and streams
// them over a valid/ready byte port.
module vram_scanout
  import vram_pkg::*;
#(
  parameter bit INVERT     = 1'b0,
  parameter bit CONTINUOUS = 1'b0
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADR_W-1:0]  gb_adr_o,
  input  logic              gb_pix_i,
  vram_scanout_if.master    m_if
);

  scan_state_t       state_q, state_n;
  logic [COL_W-1:0]  col_q;
  logic [PAGE_W-1:0] page_q;
  logic              cur_first_q, cur_last_q;
  pix_beat_t         out_q;
  logic              out_valid_q;
  logic              busy_q, done_q;

  logic              go_c, load_c, done_n, busy_n;
  logic              slot_free_c, xfer_c;
  logic [BYTE_W-1:0] byte_c;
  logic              byte_valid_c;

  vram_byte_fetch #(
    .INVERT(INVERT)
  ) u_fetch (
    .wb_clk_i    (wb_clk_i),
    .wb_rst_ni   (wb_rst_ni),
    .go_i        (go_c),
    .col_i       (col_q),
    .page_i      (page_q),
    .byte_c      (byte_c),
    .byte_valid_c(byte_valid_c),
    .gb_adr_o    (gb_adr_o),
    .gb_pix_i    (gb_pix_i)
  );

  assign xfer_c      = out_valid_q && m_if.m_ready_i;
  assign slot_free_c = !out_valid_q || m_if.m_ready_i;

  // Next state, fetch launch and output-slot load.
  always_comb begin
    state_n = state_q;
    go_c    = 1'b0;
    load_c  = 1'b0;
    done_n  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          go_c    = 1'b1;
          state_n = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (byte_valid_c) begin
          if (slot_free_c) begin
            load_c = 1'b1;
            if (cur_last_q) state_n = ST_DRAIN;
            else            go_c    = 1'b1;
          end else begin
            state_n = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (slot_free_c) begin
          load_c = 1'b1;
          if (cur_last_q) begin
            state_n = ST_DRAIN;
          end else begin
            go_c    = 1'b1;
            state_n = ST_FETCH;
          end
        end
      end
      ST_DRAIN: begin
        if (xfer_c) begin
          done_n = 1'b1;
          if (CONTINUOUS) begin
            go_c    = 1'b1;
            state_n = ST_FETCH;
          end else begin
            state_n = ST_IDLE;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
    busy_n = (state_n != ST_IDLE) && !done_n;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
    end
  end

  // Scan counters point at the next byte to fetch; flags follow the fetch.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      col_q       <= '0;
      page_q      <= '0;
      cur_first_q <= 1'b0;
      cur_last_q  <= 1'b0;
    end else if (go_c) begin
      col_q       <= col_q + COL_W'(1);
      if (col_q == COL_W'(COLS - 1)) begin
        page_q <= page_q + PAGE_W'(1);
      end
      cur_first_q <= ({page_q, col_q} == IDX_W'(0));
      cur_last_q  <= ({page_q, col_q} == IDX_W'(FRAME_BYTES - 1));
    end
  end

  // Output slot: payload only changes on load, flags clear when it empties.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else if (load_c) begin
      out_q.first <= cur_first_q;
      out_q.last  <= cur_last_q;
      out_q.dat   <= byte_c;
      out_valid_q <= 1'b1;
    end else if (xfer_c) begin
      out_q.first <= 1'b0;
      out_q.last  <= 1'b0;
      out_valid_q <= 1'b0;
    end
  end

  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign m_if.m_dat_o   = out_q.dat;
  assign m_if.m_first_o = out_q.first;
  assign m_if.m_last_o  = out_q.last;
  assign m_if.m_valid_o = out_valid_q;

endmodule

// File: tb/tb_vram_scanout.sv
// Directed bench for vram_scanout: one plain instance with a VRAM model and
// an INVERT+CONTINUOUS instance reading an all-zero VRAM.
module tb_vram_scanout;
  import vram_pkg::*;

  typedef struct packed {
    logic [7:0] dat;
    logic       first;
    logic       last;
  } beat_t;

  typedef struct {
    int          x;
    logic [31:0] word;
    int          duty;
    int          idx;
    logic [7:0]  val;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic        rst_a_n = 1'b0, start_a = 1'b0;
  logic        busy_a, done_a, pix_a = 1'b0;
  logic [11:0] adr_a;
  logic [31:0] word_a = '0;
  logic [31:0] mem_a [COLS];
  logic        rst_b_n = 1'b0, start_b = 1'b0;
  logic        busy_b, done_b;
  logic [11:0] adr_b;

  vram_scanout_if if_a ();
  vram_scanout_if if_b ();

  vram_scanout #(.INVERT(1'b0), .CONTINUOUS(1'b0)) u_a (
    .wb_clk_i(clk), .wb_rst_ni(rst_a_n), .start_i(start_a), .busy_o(busy_a),
    .done_o(done_a), .gb_adr_o(adr_a), .gb_pix_i(pix_a), .m_if(if_a));

  vram_scanout #(.INVERT(1'b1), .CONTINUOUS(1'b1)) u_b (
    .wb_clk_i(clk), .wb_rst_ni(rst_b_n), .start_i(start_b), .busy_o(busy_b),
    .done_o(done_b), .gb_adr_o(adr_b), .gb_pix_i(1'b0), .m_if(if_b));

  // VRAM model: column word register, then registered pixel select.
  always @(posedge clk) begin
    word_a <= mem_a[adr_a[11:5]];
    pix_a  <= word_a[adr_a[4:0]];
  end

  int rdy_duty = 100;
  always @(posedge clk) begin
    #1 if_a.m_ready_i = (int'($urandom_range(99)) < rdy_duty);
  end
  assign if_b.m_ready_i = 1'b1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  beat_t q_a [$];
  beat_t q_b [$];
  int    done_cnt_a = 0, done_cnt_b = 0;
  logic  stall_a = 1'b0;
  logic [9:0] stall_val = '0;

  // Stream monitor: records transfers, checks stall stability and flag qualification.
  always @(negedge clk) begin
    if (!rst_a_n) begin
      stall_a = 1'b0;
    end else begin
      if (stall_a)
        chk("stall hold", {if_a.m_valid_o, if_a.m_first_o, if_a.m_last_o, if_a.m_dat_o},
            {1'b1, stall_val});
      if (!if_a.m_valid_o)
        chk("flags without valid", {if_a.m_first_o, if_a.m_last_o}, 2'b00);
      if (if_a.m_valid_o && if_a.m_ready_i)
        q_a.push_back({if_a.m_dat_o, if_a.m_first_o, if_a.m_last_o});
      stall_a   = if_a.m_valid_o && !if_a.m_ready_i;
      stall_val = {if_a.m_first_o, if_a.m_last_o, if_a.m_dat_o};
      if (done_a) done_cnt_a++;
    end
  end

  always @(negedge clk) begin
    if (rst_b_n) begin
      if (if_b.m_valid_o && if_b.m_ready_i)
        q_b.push_back({if_b.m_dat_o, if_b.m_first_o, if_b.m_last_o});
      if (done_b) done_cnt_b++;
    end
  end

  task automatic run_frame(input int duty, input bit lat, output int cyc,
                           output int b_n, output int b_d);
    rdy_duty = duty;
    b_n = q_a.size();
    b_d = done_cnt_a;
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    cyc = 1;
    chk("busy after start", busy_a, 1);
    if (lat) begin
      chk("adr at F0", adr_a, 12'h000);
      repeat (2) @(posedge clk);
      #1 chk("adr at F2", adr_a, 12'h001);
      repeat (7) @(posedge clk);
      #1 chk("valid before cycle 11", if_a.m_valid_o, 0);
      @(posedge clk);
      #1 chk("valid at cycle 11", if_a.m_valid_o, 1);
      cyc = 11;
    end
    while (!done_a && cyc < 40000) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("frame done seen", done_a, 1);
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic check_frame(input string tag, input int idx, input logic [7:0] val,
                             input int b_n, input int b_d);
    int got, derr, ferr, first_bad;
    logic [7:0] exp;
    beat_t bt;
    got = q_a.size() - b_n;
    derr = 0; ferr = 0; first_bad = -1;
    chk({tag, " byte count"}, got, 512);
    for (int i = 0; i < 512 && i < got; i++) begin
      bt  = q_a[b_n + i];
      exp = (i == idx) ? val : 8'h00;
      if (bt.dat !== exp) begin
        derr++;
        if (first_bad < 0) first_bad = i;
      end
      if (bt.first !== (i == 0) || bt.last !== (i == 511)) ferr++;
    end
    chk($sformatf("%s data errors (first at %0d)", tag, first_bad), derr, 0);
    chk({tag, " flag errors"}, ferr, 0);
    chk({tag, " done pulses"}, done_cnt_a - b_d, 1);
    chk({tag, " idle after"}, {busy_a, if_a.m_valid_o}, 2'b00);
  endtask

  vec_t vecs [5];
  bit   b_done = 1'b0;

  initial begin
    int cyc, bn, bd, b0, d0, g;
    vecs[0] = '{x: 0,   word: 32'h0000_00FF, duty: 100, idx: 0,   val: 8'hFF};
    vecs[1] = '{x: 5,   word: 32'h0000_2000, duty: 100, idx: 133, val: 8'h20};
    vecs[2] = '{x: 127, word: 32'h8000_0000, duty: 30,  idx: 511, val: 8'h80};
    vecs[3] = '{x: 1,   word: 32'h0000_0100, duty: 50,  idx: 129, val: 8'h01};
    vecs[4] = '{x: 100, word: 32'h3C00_0000, duty: 30,  idx: 484, val: 8'h3C};
    for (int i = 0; i < COLS; i++) mem_a[i] = '0;

    repeat (3) @(posedge clk);
    #1 chk("A reset outputs", {busy_a, done_a, if_a.m_valid_o, if_a.m_first_o,
                               if_a.m_last_o, if_a.m_dat_o, adr_a}, 0);
    rst_a_n = 1'b1;

    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < COLS; i++) mem_a[i] = '0;
      mem_a[vecs[v].x] = vecs[v].word;
      run_frame(vecs[v].duty, v == 0, cyc, bn, bd);
      if (vecs[v].duty == 100) chk($sformatf("vec%0d frame cycles", v), cyc, 5122);
      check_frame($sformatf("vec%0d", v), vecs[v].idx, vecs[v].val, bn, bd);
      if (v == 0) chk("adr held after frame", adr_a, 12'hFFF);
    end

    // Reset mid-frame right after byte 200 is accepted.
    for (int i = 0; i < COLS; i++) mem_a[i] = '0;
    mem_a[5] = 32'h0000_2000;
    rdy_duty = 100;
    b0 = q_a.size();
    d0 = done_cnt_a;
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    g = 0;
    while (q_a.size() - b0 < 201 && g < 20000) begin
      @(negedge clk);
      g++;
    end
    chk("reached byte 200", q_a.size() - b0, 201);
    @(posedge clk);
    #2 rst_a_n = 1'b0;
    #1 chk("mid-frame reset outputs", {busy_a, done_a, if_a.m_valid_o, if_a.m_first_o,
                                       if_a.m_last_o, if_a.m_dat_o, adr_a}, 0);
    repeat (3) @(posedge clk);
    #1 chk("no done from aborted frame", done_cnt_a - d0, 0);
    rst_a_n = 1'b1;
    run_frame(100, 1'b0, cyc, bn, bd);
    chk("post-reset frame cycles", cyc, 5122);
    check_frame("post-reset", 133, 8'h20, bn, bd);

    // start_i pulsed while busy is ignored.
    for (int i = 0; i < COLS; i++) mem_a[i] = '0;
    mem_a[64] = 32'h00A5_0000;
    b0 = q_a.size();
    g = 0;
    fork
      run_frame(50, 1'b0, cyc, bn, bd);
      begin
        while (q_a.size() - b0 < 50 && g < 20000) begin
          @(posedge clk);
          g++;
        end
        #1 start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
      end
    join
    check_frame("start ignored", 320, 8'hA5, bn, bd);
    repeat (30) @(posedge clk);
    #1 chk("no restart busy", busy_a, 0);
    chk("no restart bytes", q_a.size() - bn, 512);

    g = 0;
    while (!b_done && g < 30000) begin
      @(posedge clk);
      g++;
    end
    chk("B sequence finished", b_done, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // INVERT=1, CONTINUOUS=1 against an all-zero VRAM: two back-to-back frames of 0xFF.
  initial begin
    int g, berr, ferr;
    beat_t bt;
    repeat (3) @(posedge clk);
    #1 chk("B reset outputs", {busy_b, done_b, if_b.m_valid_o, if_b.m_first_o,
                               if_b.m_last_o, if_b.m_dat_o, adr_b}, 0);
    rst_b_n = 1'b1;
    @(posedge clk); #1 start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    g = 0;
    while (done_cnt_b < 2 && g < 15000) begin
      @(posedge clk);
      g++;
    end
    #1 chk("B two frames done", done_cnt_b, 2);
    chk("B byte count", q_b.size(), 1024);
    berr = 0; ferr = 0;
    for (int i = 0; i < q_b.size() && i < 1024; i++) begin
      bt = q_b[i];
      if (bt.dat !== 8'hFF) berr++;
      if (bt.first !== (i % 512 == 0) || bt.last !== (i % 512 == 511)) ferr++;
    end
    chk("B inverted data errors", berr, 0);
    chk("B flag errors", ferr, 0);
    if (q_b.size() > 512) begin
      bt = q_b[512];
      chk("B second frame first", bt.first, 1);
    end else begin
      chk("B second frame present", q_b.size(), 1024);
    end
    repeat (3) @(posedge clk);
    #1 chk("B restarted busy", busy_b, 1);
    b_done = 1'b1;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/vram_scanout.md
Name: vram_scanout

Overview:
- Read-side master for the VRAM pixel port; it is the block that drives the port's address and consumes its single-bit pixel output.
- Scans the 128x32x1bpp framebuffer and packs pixels into page-format bytes: 4 pages of 8 rows, bit0 = top row, column-major within a page.
- Streams the bytes over a valid/ready byte interface to the downstream display serializer.
- Shares the VRAM clock.

Parameters:
- INVERT, 0: 1 inverts every pixel before packing.
- CONTINUOUS, 0: 1 restarts a new frame automatically after each frame completes.

Ports:
- wb_clk_i  in  1  system clock; also the VRAM clock.
- wb_rst_ni  in  1  reset; asynchronous assert, active-low.
- start_i  in  1  one-cycle pulse; begins a frame when idle.
- busy_o  out  1  high from frame start until the last byte is accepted.
- done_o  out  1  one-cycle pulse after the last byte is accepted.
- gb_adr_o  out  12  pixel address to VRAM: [11:5] = column x (0..127), [4:0] = row y (0..31).
- gb_pix_i  in  1  pixel from VRAM; registered, 2-cycle pipeline.
- m_dat_o  out  8  packed byte.
- m_valid_o  out  1  byte valid.
- m_ready_i  in  1  downstream accept.
- m_first_o  out  1  qualifies byte 0 of the frame.
- m_last_o  out  1  qualifies byte 511 of the frame.

Behaviour:
- Reset: all outputs are 0, FSM is IDLE, all counters are 0. Assertion takes effect immediately, including mid-frame. The partial frame is discarded and no done_o is generated.
- Clock and reset: one clock, wb_clk_i. Reset wb_rst_ni is asynchronous and active-low.
- VRAM port timing:
  - The VRAM word register loads from the x presented at cycle t.
  - gb_pix_i at cycle t+1 = word[y presented at t].
  - x must therefore be stable at least 1 cycle before the y it qualifies.
- Byte fetch (column c, page p), 10 cycles, F0..F9:
  - F0: drive x=c, y=8p.
  - Fk for k=1..8: drive x=c, y=8p+(k-1).
  - Bit k-2 is captured from gb_pix_i at Fk for k=2..9.
  - The pixel is XORed with INVERT before capture.
  - gb_adr_o holds its last value outside fetch.
- Scan order: p=0..3 outer, c=0..127 inner. Byte index = p*128+c, 512 bytes per frame.
- FSM states: IDLE, FETCH, HOLD, DRAIN.
  - IDLE -> FETCH on start_i. busy_o rises the next cycle.
  - FETCH completes after 10 cycles into the assembly register.
  - If the output register is empty, or is emptied that same cycle, the byte moves to the output register and the next fetch starts immediately.
  - Otherwise go to HOLD and stall until the output slot frees.
  - After byte 511 is fetched, go to DRAIN. When byte 511 is accepted, pulse done_o and drop busy_o.
  - Then return to IDLE, or re-enter FETCH next cycle if CONTINUOUS=1.
- Output handshake:
  - Transfer occurs when m_valid_o && m_ready_i.
  - m_dat_o, m_first_o and m_last_o are stable while m_valid_o && !m_ready_i.
  - m_valid_o never drops without a transfer.
  - m_first_o / m_last_o are asserted only alongside valid.
- Throughput: with m_ready_i held high, one byte every 10 cycles. The first m_valid_o comes 11 cycles after start_i.
- start_i while busy is ignored.
- Coherency: VRAM writes during a scan are visible at column-word granularity. No frame coherence is provided.
- Counters: column 7 bits and page 2 bits, wrapping 127->0 with page increment. Bit counter 3 bits. No overflow beyond page 3.

Decomposition:
- vram_pkg holds: COLS=128, ROWS=32, PAGES=4, ADR_W=12, X_LSB=5, Y_W=5, FETCH_CYC=10, FRAME_BYTES=512.
- Sub-module vram_byte_fetch:
  - Inputs: column, page, go. Outputs: byte, byte_valid. Drives gb_adr_o, samples gb_pix_i.
  - It owns the F0..F9 sequencing.
- The top level holds the FSM, the scan counters and the output register.

Test Plan:
1. Word x=0 = 0x000000FF, rest 0, ready=1, start -> byte0=0xFF with m_first_o=1, bytes 1..511=0x00, m_last_o on byte 511, done_o one pulse, busy_o low afterwards.
2. Single pixel x=5, y=13 set -> only byte 133 = 0x20, all others 0x00.
3. Random m_ready_i (30% duty) with a reference model -> exactly 512 transfers, no loss or duplication, data and flags stable across stalls.
4. INVERT=1, VRAM all zero -> 512 bytes of 0xFF. CONTINUOUS=1 -> second frame begins without start_i and m_first_o recurs.
5. Reset pulsed after byte 200 accepted -> all outputs 0 immediately. A following start_i yields a full 512-byte frame from byte 0.
6. start_i pulsed at byte 50 of an active frame -> ignored, frame completes normally with one done_o.
